// File: rtl/pixel_plot_receiver.sv
`timescale 1ns/1ps
// Pixel-address sink: buffers plot beats in a 4-deep fall-through FIFO, range-checks them,
// linearises (x,y) into a 320x240 framebuffer address, and can sweep the buffer to BG_COLOUR.
module pixel_plot_receiver #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int X_W    = 9,
    parameter int Y_W    = 8,
    parameter int COL_W  = 3,
    parameter int ADDR_W = 17,
    parameter logic [COL_W-1:0] BG_COLOUR = '0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [X_W-1:0]    xAdd,
    input  logic [Y_W-1:0]    yAdd,
    input  logic [COL_W-1:0]  colour,
    input  logic              plotEnable,
    output logic              ready,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [COL_W-1:0]  fb_data,
    output logic              fb_we,
    output logic              busy,
    output logic [ADDR_W-1:0] pixel_count,
    output logic              oob_err,
    output logic              o_dbg_state
);

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    localparam int BEAT_W = X_W + Y_W + COL_W;
    localparam logic [X_W:0]    LP_H_LIM  = (X_W+1)'(H_RES);
    localparam logic [Y_W:0]    LP_V_LIM  = (Y_W+1)'(V_RES);
    localparam logic [ADDR_W-1:0] LP_ROW  = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(H_RES*V_RES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [BEAT_W-1:0]   r_fifo [0:3];
    logic [1:0]          r_wr_ptr;
    logic [1:0]          r_rd_ptr;
    logic [2:0]          r_count;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   r_fb_addr;
    logic [COL_W-1:0]    r_fb_data;
    logic                r_fb_we;
    logic [ADDR_W-1:0]   r_pixel_count;
    logic                r_oob_err;

    logic                w_push;
    logic                w_pop;
    logic [BEAT_W-1:0]   w_head;
    logic [X_W-1:0]      w_head_x;
    logic [Y_W-1:0]      w_head_y;
    logic [COL_W-1:0]    w_head_c;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_pix_addr;

    // Handshake: a beat transfers at a rising edge when plotEnable and ready are both high;
    // ready depends only on the registered count, so a full FIFO never pushes even if it pops.
    assign ready  = (r_count != 3'd4);
    assign w_push = plotEnable & ready;

    assign w_head   = r_fifo[r_rd_ptr];
    assign w_head_x = w_head[BEAT_W-1 -: X_W];
    assign w_head_y = w_head[COL_W +: Y_W];
    assign w_head_c = w_head[COL_W-1:0];

    assign w_in_range = ({1'b0, w_head_x} < LP_H_LIM) && ({1'b0, w_head_y} < LP_V_LIM);
    // Row term kept at full address width so y*320 never truncates.
    assign w_pix_addr = (ADDR_W'(w_head_y) * LP_ROW) + ADDR_W'(w_head_x);

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_req) begin
                    w_next_state = ST_CLEAR;
                end else if (r_count != 3'd0) begin
                    w_pop = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (r_clr_cnt == LP_LAST) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {xAdd, yAdd, colour};
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_clr_cnt     <= '0;
            r_fb_addr     <= '0;
            r_fb_data     <= '0;
            r_fb_we       <= 1'b0;
            r_pixel_count <= '0;
            r_oob_err     <= 1'b0;
        end else begin
            r_fb_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        r_clr_cnt     <= '0;
                        r_pixel_count <= '0;
                        r_oob_err     <= 1'b0;
                    end else if (w_pop) begin
                        if (w_in_range) begin
                            r_fb_addr <= w_pix_addr;
                            r_fb_data <= w_head_c;
                            r_fb_we   <= 1'b1;
                            if (r_pixel_count != {ADDR_W{1'b1}}) begin
                                r_pixel_count <= r_pixel_count + 1'b1;
                            end
                        end else begin
                            r_oob_err <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_fb_addr <= r_clr_cnt;
                    r_fb_data <= BG_COLOUR;
                    r_fb_we   <= 1'b1;
                    r_clr_cnt <= (r_clr_cnt == LP_LAST) ? '0 : r_clr_cnt + 1'b1;
                end
                default: r_fb_we <= 1'b0;
            endcase
        end
    end

    assign fb_addr     = r_fb_addr;
    assign fb_data     = r_fb_data;
    assign fb_we       = r_fb_we;
    assign pixel_count = r_pixel_count;
    assign oob_err     = r_oob_err;
    assign busy        = (r_state == ST_CLEAR) || (r_count != 3'd0);
    assign o_dbg_state = r_state;

endmodule
